// File: rtl/bf_loop_ctrl.sv
// bf_loop_ctrl: bracket loop sequencer with a return-address stack for the brainfuck CPU
// Ports: clk_in/reset_in (async, active-high), op_valid_in/op_code_in/pc_in/cell_zero_in (decoded op),
//   op_ready_out (handshake), skip_out (accepted op must not execute), pc_load_out/pc_target_out (PC redirect),
//   err_overflow_out/err_underflow_out (sticky errors).
// Option BF_LOOP_CTRL_DEPTH_STAT_EN adds max_depth_out, the stack-pointer high-water mark.
module bf_loop_ctrl #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 16,
  parameter int SKIP_MAX    = 255
) (
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic                           op_valid_in,
  input  logic [2:0]                     op_code_in,
  input  logic [PC_WIDTH-1:0]            pc_in,
  input  logic                           cell_zero_in,
  output logic                           op_ready_out,
  output logic                           skip_out,
  output logic                           pc_load_out,
  output logic [PC_WIDTH-1:0]            pc_target_out,
  output logic                           err_overflow_out,
  output logic                           err_underflow_out
`ifdef BF_LOOP_CTRL_DEPTH_STAT_EN
  ,
  output logic [$clog2(STACK_DEPTH):0]   max_depth_out
`endif
);
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;
  localparam int DW  = $clog2(SKIP_MAX + 1);
  localparam logic [2:0] OP_OPEN  = 3'd6;
  localparam logic [2:0] OP_CLOSE = 3'd7;
  typedef enum logic [1:0] {RUN, SKIP, JUMP, ERR} state_t;
  state_t                state_q, state_d;
  logic [SPW-1:0]        sp_q, sp_d, sp_m1;
  logic [DW-1:0]         skip_q, skip_d;
  logic [PC_WIDTH-1:0]   tgt_q, tgt_d, top;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  acc, push;
  logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];
  assign op_ready_out      = (state_q == RUN) || (state_q == SKIP);
  assign skip_out          = state_q == SKIP;
  assign pc_load_out       = state_q == JUMP;
  assign pc_target_out     = tgt_q;
  assign err_overflow_out  = ovf_q;
  assign err_underflow_out = unf_q;
  assign acc   = op_valid_in && op_ready_out;
  assign sp_m1 = sp_q - SPW'(1);
  assign top   = stack_q[sp_m1[AW-1:0]];
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    skip_d  = skip_q;
    tgt_d   = tgt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (state_q)
      RUN: begin
        if (acc && op_code_in == OP_OPEN) begin
          if (cell_zero_in) begin
            skip_d  = DW'(1);
            state_d = SKIP;
          end else if (sp_q == SPW'(STACK_DEPTH)) begin
            ovf_d   = 1'b1;
            state_d = ERR;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
          end
        end else if (acc && op_code_in == OP_CLOSE) begin
          // empty-stack check takes priority over the cell value
          if (sp_q == '0) begin
            unf_d   = 1'b1;
            state_d = ERR;
          end else if (cell_zero_in) begin
            sp_d = sp_m1;
          end else begin
            tgt_d   = top + PC_WIDTH'(1);
            state_d = JUMP;
          end
        end
      end
      SKIP: begin
        if (acc && op_code_in == OP_OPEN) begin
          if (skip_q == DW'(SKIP_MAX)) begin
            ovf_d   = 1'b1;
            state_d = ERR;
          end else begin
            skip_d = skip_q + DW'(1);
          end
        end else if (acc && op_code_in == OP_CLOSE) begin
          skip_d  = skip_q - DW'(1);
          state_d = (skip_q == DW'(1)) ? RUN : SKIP;
        end
      end
      JUMP:    state_d = RUN;
      default: state_d = ERR;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= RUN;
      sp_q    <= '0;
      skip_q  <= '0;
      tgt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      skip_q  <= skip_d;
      tgt_q   <= tgt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // stack storage needs no reset: entries above sp are never read
  always_ff @(posedge clk_in) begin
    if (push) stack_q[sp_q[AW-1:0]] <= pc_in;
  end
`ifdef BF_LOOP_CTRL_DEPTH_STAT_EN
  logic [SPW-1:0] max_depth_q, max_depth_d;
  // tracks the registered sp, so a push shows up one cycle later
  assign max_depth_d   = (sp_q > max_depth_q) ? sp_q : max_depth_q;
  assign max_depth_out = max_depth_q;
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) max_depth_q <= '0;
    else          max_depth_q <= max_depth_d;
  end
`endif
endmodule

// File: tb/tb_bf_loop_ctrl.sv
// tb_bf_loop_ctrl: scoreboard bench for bf_loop_ctrl
module tb_bf_loop_ctrl;
  localparam int PW = 8;
  localparam int SD = 4;
  localparam int SM = 3;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [2:0]    opc = '0;
  logic [PW-1:0] pc = '0;
  logic          cz = 1'b0;
  logic          op_ready_out, skip_out, pc_load_out, err_overflow_out, err_underflow_out;
  logic [PW-1:0] pc_target_out;
`ifdef BF_LOOP_CTRL_DEPTH_STAT_EN
  logic [$clog2(SD):0] max_depth_out;
`endif
  int vectors = 0;
  int miscompares = 0;
  int w;
  logic          skq[$];
  logic [PW-1:0] tq[$];
  logic [PW-1:0] t;
  bf_loop_ctrl #(.PC_WIDTH(PW), .STACK_DEPTH(SD), .SKIP_MAX(SM)) dut (
    .clk_in(clk), .reset_in(rst), .op_valid_in(valid), .op_code_in(opc), .pc_in(pc),
    .cell_zero_in(cz), .op_ready_out(op_ready_out), .skip_out(skip_out),
    .pc_load_out(pc_load_out), .pc_target_out(pc_target_out),
    .err_overflow_out(err_overflow_out), .err_underflow_out(err_underflow_out)
`ifdef BF_LOOP_CTRL_DEPTH_STAT_EN
    , .max_depth_out(max_depth_out)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && pc_load_out) begin
      vectors++;
      if (tq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_load got pc_load=1 target=%0d want pc_load=0", pc_target_out);
      end else begin
        t = tq.pop_front();
        vectors++;
        if (pc_target_out !== t) begin
          miscompares++;
          $display("FAIL load_target got %0d want %0d", pc_target_out, t);
        end
      end
    end
  end
  task automatic issue(input logic [2:0] o, input logic [PW-1:0] p, input logic c,
                       input logic exp_skip, output int waits);
    logic e;
    @(negedge clk);
    valid = 1'b1; opc = o; pc = p; cz = c;
    skq.push_back(exp_skip);
    waits = 0;
    while (!op_ready_out && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    vectors++;
    if (!op_ready_out) begin
      miscompares++;
      $display("FAIL accept_timeout op=%0d got ready=0 want 1", o);
      void'(skq.pop_front());
    end else begin
      e = skq.pop_front();
      vectors++;
      if (skip_out !== e) begin
        miscompares++;
        $display("FAIL skip op=%0d pc=%0d got %0b want %0b", o, p, skip_out, e);
      end
      @(posedge clk);
    end
    #1 valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    issue(3'd6, 8'd0, 1'b1, 1'b0, w);
    vectors++;
    if (skip_out !== 1'b1) begin miscompares++; $display("FAIL pre_reset_skip got %0b want 1", skip_out); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({op_ready_out, skip_out, pc_load_out, err_overflow_out, err_underflow_out} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy/skip/load/ovf/unf=%b want 10000",
               {op_ready_out, skip_out, pc_load_out, err_overflow_out, err_underflow_out});
    end
    vectors++;
    if (pc_target_out !== 8'd0) begin miscompares++; $display("FAIL reset_target got %0d want 0", pc_target_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_passthrough();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(3'(i), 8'(i + 20), i[0], 1'b0, w);
      vectors++;
      if (w !== 0) begin miscompares++; $display("FAIL pass_latency op=%0d got %0d want 0", i, w); end
    end
    vectors++;
    if ({op_ready_out, pc_load_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL pass_state got rdy/load=%b want 10", {op_ready_out, pc_load_out});
    end
  endtask
  task automatic test_loop_back();
    do_reset();
    issue(3'd6, 8'd3, 1'b0, 1'b0, w);
    tq.push_back(8'd4);
    issue(3'd7, 8'd7, 1'b0, 1'b0, w);
    vectors++;
    if ({pc_load_out, op_ready_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL jump_handshake got load/rdy=%b want 10", {pc_load_out, op_ready_out});
    end
    vectors++;
    if (pc_target_out !== 8'd4) begin miscompares++; $display("FAIL jump_target got %0d want 4", pc_target_out); end
    issue(3'd7, 8'd7, 1'b1, 1'b0, w);
    vectors++;
    if (w !== 1) begin miscompares++; $display("FAIL jump_backpressure got waits=%0d want 1", w); end
    vectors++;
    if (pc_load_out !== 1'b0 || pc_target_out !== 8'd4) begin
      miscompares++;
      $display("FAIL pop_no_load got load=%0b target=%0d want load=0 target=4", pc_load_out, pc_target_out);
    end
`ifdef BF_LOOP_CTRL_DEPTH_STAT_EN
    vectors++;
    if (max_depth_out !== 3'd1) begin miscompares++; $display("FAIL loop_max_depth got %0d want 1", max_depth_out); end
`endif
    issue(3'd7, 8'd8, 1'b0, 1'b0, w);
    vectors++;
    if ({err_underflow_out, op_ready_out, err_overflow_out} !== 3'b100) begin
      miscompares++;
      $display("FAIL empty_after_pop got unf/rdy/ovf=%b want 100", {err_underflow_out, op_ready_out, err_overflow_out});
    end
    @(negedge clk);
    vectors++;
    if (tq.size() !== 0) begin miscompares++; $display("FAIL loop_pending_loads got %0d want 0", tq.size()); end
  endtask
  task automatic test_skip_nested();
    do_reset();
    issue(3'd6, 8'd2, 1'b1, 1'b0, w);
    issue(3'd6, 8'd3, 1'b0, 1'b1, w);
    issue(3'd7, 8'd4, 1'b0, 1'b1, w);
    issue(3'd2, 8'd5, 1'b0, 1'b1, w);
    issue(3'd7, 8'd6, 1'b0, 1'b1, w);
    vectors++;
    if ({skip_out, op_ready_out} !== 2'b01) begin
      miscompares++;
      $display("FAIL skip_exit got skip/rdy=%b want 01", {skip_out, op_ready_out});
    end
    issue(3'd7, 8'd7, 1'b0, 1'b0, w);
    vectors++;
    if (err_underflow_out !== 1'b1) begin miscompares++; $display("FAIL skip_sp_untouched got unf=%0b want 1", err_underflow_out); end
  endtask
  task automatic test_skip_overflow();
    do_reset();
    issue(3'd6, 8'd0, 1'b1, 1'b0, w);
    for (int i = 1; i < 4; i++) issue(3'd6, 8'(i), 1'b0, 1'b1, w);
    vectors++;
    if ({err_overflow_out, op_ready_out, skip_out, err_underflow_out} !== 4'b1000) begin
      miscompares++;
      $display("FAIL skip_overflow got ovf/rdy/skip/unf=%b want 1000",
               {err_overflow_out, op_ready_out, skip_out, err_underflow_out});
    end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) issue(3'd6, 8'(i), 1'b0, 1'b0, w);
    vectors++;
    if ({err_overflow_out, op_ready_out} !== 2'b10) begin
      miscompares++;
      $display("FAIL stack_overflow got ovf/rdy=%b want 10", {err_overflow_out, op_ready_out});
    end
`ifdef BF_LOOP_CTRL_DEPTH_STAT_EN
    vectors++;
    if (max_depth_out !== 3'd4) begin miscompares++; $display("FAIL ovf_max_depth got %0d want 4", max_depth_out); end
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if ({err_overflow_out, op_ready_out, pc_target_out} !== {2'b10, 8'd0}) begin
      miscompares++;
      $display("FAIL err_hold got ovf=%0b rdy=%0b target=%0d want ovf=1 rdy=0 target=0",
               err_overflow_out, op_ready_out, pc_target_out);
    end
  endtask
  task automatic test_underflow();
    do_reset();
    issue(3'd7, 8'd9, 1'b0, 1'b0, w);
    @(negedge clk);
    vectors++;
    if ({err_underflow_out, err_overflow_out, pc_load_out, op_ready_out} !== 4'b1000) begin
      miscompares++;
      $display("FAIL underflow got unf/ovf/load/rdy=%b want 1000",
               {err_underflow_out, err_overflow_out, pc_load_out, op_ready_out});
    end
  endtask
  task automatic test_wrap_back_to_back();
    do_reset();
    issue(3'd6, 8'd255, 1'b0, 1'b0, w);
    tq.push_back(8'd0);
    issue(3'd7, 8'd10, 1'b0, 1'b0, w);
    vectors++;
    if ({pc_load_out, pc_target_out} !== {1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL wrap_target got load=%0b target=%0d want load=1 target=0", pc_load_out, pc_target_out);
    end
    issue(3'd2, 8'd11, 1'b0, 1'b0, w);
    vectors++;
    if (w !== 1) begin miscompares++; $display("FAIL held_op_waits got %0d want 1", w); end
    vectors++;
    if (pc_load_out !== 1'b0) begin miscompares++; $display("FAIL single_pulse got load=%0b want 0", pc_load_out); end
`ifdef BF_LOOP_CTRL_DEPTH_STAT_EN
    vectors++;
    if (max_depth_out !== 3'd1) begin miscompares++; $display("FAIL wrap_max_depth got %0d want 1", max_depth_out); end
`endif
    @(negedge clk);
    vectors++;
    if (tq.size() !== 0) begin miscompares++; $display("FAIL wrap_pending_loads got %0d want 0", tq.size()); end
  endtask
  task automatic test_reset_mid_jump();
    do_reset();
    issue(3'd6, 8'd40, 1'b0, 1'b0, w);
    issue(3'd7, 8'd41, 1'b0, 1'b0, w);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({pc_load_out, op_ready_out, pc_target_out} !== {2'b01, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_jump got load=%0b rdy=%0b target=%0d want load=0 rdy=1 target=0",
               pc_load_out, op_ready_out, pc_target_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_passthrough();
    test_loop_back();
    test_skip_nested();
    test_skip_overflow();
    test_overflow();
    test_underflow();
    test_wrap_back_to_back();
    test_reset_mid_jump();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
